// File: rtl/row_clear_controller_if.sv
// rtl/row_clear_controller_if.sv - board memory port between row-clear controller and board RAM
interface row_clear_controller_if #(
    parameter int CW = 3
) ();
    logic [3:0]    memX;
    logic [4:0]    memY;
    logic          memWE;
    logic [CW-1:0] memWData;
    logic [CW-1:0] memRData;

    modport master (
        output memX,
        output memY,
        output memWE,
        output memWData,
        input  memRData
    );

    modport slave (
        input  memX,
        input  memY,
        input  memWE,
        input  memWData,
        output memRData
    );
endinterface

// File: rtl/row_clear_controller.sv
// rtl/row_clear_controller.sv - scans the board bottom-up, removes full rows and shifts the stack down
module row_clear_controller #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int CW      = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     Resetn,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [4:0]               linesCleared,
    row_clear_controller_if.master   mem
);
    localparam logic [3:0] XMAX = 4'(BOARD_W - 1);
    localparam logic [4:0] YMAX = 5'(BOARD_H - 1);
    localparam logic [4:0] CMAX = 5'(BOARD_H);

    typedef enum logic [2:0] {
        IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, TOP_CLR, DONE
    } state_t;

    state_t     state, state_n;
    logic [4:0] y, y_n;
    logic [3:0] x, x_n;
    logic [4:0] r, r_n;
    logic [4:0] count, count_n;
    logic [4:0] lines_n;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state        <= IDLE;
            y            <= '0;
            x            <= '0;
            r            <= '0;
            count        <= '0;
            linesCleared <= '0;
        end else begin
            state        <= state_n;
            y            <= y_n;
            x            <= x_n;
            r            <= r_n;
            count        <= count_n;
            linesCleared <= lines_n;
        end
    end

    always_comb begin
        state_n      = state;
        y_n          = y;
        x_n          = x;
        r_n          = r;
        count_n      = count;
        lines_n      = linesCleared;
        busy         = (state != IDLE);
        done         = 1'b0;
        mem.memX     = '0;
        mem.memY     = '0;
        mem.memWE    = 1'b0;
        mem.memWData = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    count_n = '0;
                    lines_n = '0;
                    y_n     = YMAX;
                    x_n     = '0;
                    state_n = SCAN_RD;
                end
            end
            SCAN_RD: begin
                mem.memX = x;
                mem.memY = y;
                state_n  = SCAN_CHK;
            end
            SCAN_CHK: begin
                // Any empty cell ends the row check early; the row above is next
                if (mem.memRData == '0) begin
                    if (y == '0) begin
                        state_n = DONE;
                    end else begin
                        y_n     = y - 5'd1;
                        x_n     = '0;
                        state_n = SCAN_RD;
                    end
                end else if (x != XMAX) begin
                    x_n     = x + 4'd1;
                    state_n = SCAN_RD;
                end else begin
                    r_n     = y;
                    x_n     = '0;
                    state_n = (y != '0) ? SHIFT_RD : TOP_CLR;
                end
            end
            SHIFT_RD: begin
                mem.memX = x;
                mem.memY = r - 5'd1;
                state_n  = SHIFT_WR;
            end
            SHIFT_WR: begin
                mem.memX     = x;
                mem.memY     = r;
                mem.memWE    = 1'b1;
                mem.memWData = mem.memRData;
                if (x != XMAX) begin
                    x_n     = x + 4'd1;
                    state_n = SHIFT_RD;
                end else begin
                    x_n = '0;
                    if (r == 5'd1) begin
                        state_n = TOP_CLR;
                    end else begin
                        r_n     = r - 5'd1;
                        state_n = SHIFT_RD;
                    end
                end
            end
            TOP_CLR: begin
                mem.memX  = x;
                mem.memWE = 1'b1;
                if (x != XMAX) begin
                    x_n = x + 4'd1;
                end else begin
                    // Same y is re-scanned: it now holds the row that slid down
                    if (count < CMAX) count_n = count + 5'd1;
                    x_n     = '0;
                    state_n = SCAN_RD;
                end
            end
            DONE: begin
                lines_n = count;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_row_clear_controller.sv
// tb/tb_row_clear_controller.sv - directed table-driven bench for row_clear_controller
module tb_row_clear_controller;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CW      = 3;
    localparam int LIMIT   = 2000;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       start    = 1'b0;
    logic       busy, done;
    logic [4:0] linesCleared;

    row_clear_controller_if #(.CW(CW)) mem ();

    row_clear_controller #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .CW(CW)) dut (
        .CLOCK_50     (CLOCK_50),
        .Resetn       (Resetn),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .linesCleared (linesCleared),
        .mem          (mem.master)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [CW-1:0] board  [BOARD_H][BOARD_W];
    logic [CW-1:0] init_b [BOARD_H][BOARD_W];
    logic [CW-1:0] exp_b  [BOARD_H][BOARD_W];
    logic [CW-1:0] rd_q;
    logic          load_en = 1'b0;

    always @(posedge CLOCK_50) begin
        if (load_en) begin
            board <= init_b;
        end else if (mem.memWE) begin
            board[mem.memY][mem.memX] <= mem.memWData;
        end
        rd_q <= board[mem.memY][mem.memX];
    end
    assign mem.memRData = rd_q;

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int scen;
        int exp_cycle;
        int exp_lines;
        int exp_writes;
    } vec_t;

    vec_t vecs [5];

    task automatic load_scen(input int s);
        for (int yy = 0; yy < BOARD_H; yy++)
            for (int xx = 0; xx < BOARD_W; xx++)
                init_b[yy][xx] = '0;
        case (s)
            1: begin
                for (int xx = 0; xx < BOARD_W; xx++) init_b[19][xx] = 3'd2;
                init_b[18][3] = 3'd5;
            end
            2: begin
                for (int xx = 0; xx < BOARD_W; xx++) begin
                    init_b[19][xx] = 3'd4;
                    init_b[18][xx] = 3'(xx % 7 + 1);
                end
                init_b[17][0] = 3'd1;
            end
            3: for (int xx = 0; xx < BOARD_W; xx++) init_b[0][xx] = 3'd6;
            4: begin
                for (int xx = 0; xx < BOARD_W; xx++) init_b[19][xx] = 3'd3;
                init_b[0][5] = 3'd7;
            end
            default: ;
        endcase
        @(negedge CLOCK_50) load_en = 1'b1;
        @(negedge CLOCK_50) load_en = 1'b0;
    endtask

    // Reference: drop every full row and let the rows above fall, top filled with empties
    task automatic build_exp();
        int dst;
        bit full;
        for (int yy = 0; yy < BOARD_H; yy++)
            for (int xx = 0; xx < BOARD_W; xx++)
                exp_b[yy][xx] = '0;
        dst = BOARD_H - 1;
        for (int src = BOARD_H - 1; src >= 0; src--) begin
            full = 1'b1;
            for (int xx = 0; xx < BOARD_W; xx++)
                if (init_b[src][xx] == '0) full = 1'b0;
            if (!full) begin
                for (int xx = 0; xx < BOARD_W; xx++) exp_b[dst][xx] = init_b[src][xx];
                dst--;
            end
        end
    endtask

    function automatic int board_diffs();
        int n = 0;
        for (int yy = 0; yy < BOARD_H; yy++)
            for (int xx = 0; xx < BOARD_W; xx++)
                if (board[yy][xx] !== exp_b[yy][xx]) n++;
        return n;
    endfunction

    task automatic run_pass(output int cyc, output int wr, output int bz, output int ln);
        wr = 0;
        bz = 0;
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50) start = 1'b0;
        cyc = 1;
        while (!done && cyc < LIMIT) begin
            bz += int'(busy);
            wr += int'(mem.memWE);
            @(negedge CLOCK_50);
            cyc++;
        end
        if (!done) cyc = -1;
        @(negedge CLOCK_50) ln = int'(linesCleared);
    endtask

    initial begin
        int cyc, wr, bz, ln, dones, k;

        vecs[0] = '{scen: 0, exp_cycle: 41,  exp_lines: 0, exp_writes: 0};
        vecs[1] = '{scen: 1, exp_cycle: 451, exp_lines: 1, exp_writes: 200};
        vecs[2] = '{scen: 2, exp_cycle: 863, exp_lines: 2, exp_writes: 400};
        vecs[3] = '{scen: 3, exp_cycle: 71,  exp_lines: 1, exp_writes: 10};
        vecs[4] = '{scen: 4, exp_cycle: 451, exp_lines: 1, exp_writes: 200};

        repeat (3) @(negedge CLOCK_50);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_done",  int'(done), 0);
        chk("reset_we",    int'(mem.memWE), 0);
        chk("reset_lines", int'(linesCleared), 0);
        chk("reset_addr",  int'({mem.memX, mem.memY, mem.memWData}), 0);
        Resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load_scen(vecs[i].scen);
            build_exp();
            run_pass(cyc, wr, bz, ln);
            chk($sformatf("v%0d_done_cycle", i), cyc, vecs[i].exp_cycle);
            chk($sformatf("v%0d_busy_cycles", i), bz, vecs[i].exp_cycle - 1);
            chk($sformatf("v%0d_writes", i), wr, vecs[i].exp_writes);
            chk($sformatf("v%0d_lines", i), ln, vecs[i].exp_lines);
            chk($sformatf("v%0d_board_diffs", i), board_diffs(), 0);
            chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
            chk($sformatf("v%0d_idle_addr", i), int'({mem.memX, mem.memY, mem.memWE}), 0);
        end

        // Reset asserted during the first SHIFT_WR cycle
        load_scen(1);
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50) start = 1'b0;
        k = 0;
        while (!(mem.memWE && mem.memY == 5'd19) && k < 100) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk("rst_reach_shift_wr", int'(k < 100), 1);
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_we",    int'(mem.memWE), 0);
        chk("rst_lines", int'(linesCleared), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_addr",  int'({mem.memX, mem.memY, mem.memWData}), 0);
        Resetn = 1'b1;
        load_scen(0);
        run_pass(cyc, wr, bz, ln);
        chk("post_rst_cycle", cyc, 41);
        chk("post_rst_lines", ln, 0);

        // start re-asserted mid-pass; linesCleared cleared when new pass begins
        load_scen(3);
        run_pass(cyc, wr, bz, ln);
        chk("pre_lines", ln, 1);
        load_scen(0);
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50) start = 1'b0;
        chk("restart_lines_cleared", int'(linesCleared), 0);
        chk("restart_busy", int'(busy), 1);
        dones = 0;
        for (int c = 2; c <= 120; c++) begin
            @(negedge CLOCK_50);
            dones += int'(done);
            start = (c == 10);
        end
        start = 1'b0;
        chk("single_done_pulse", dones, 1);
        chk("final_idle", int'(busy), 0);
        chk("final_lines", int'(linesCleared), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/row_clear_controller.md
ROW_CLEAR_CONTROLLER -- requirements
Module: row_clear_controller

Interface
REQ-001 Parameters SHALL be: BOARD_W, 10, board columns; BOARD_H, 20, board rows; CW, 3, cell colour width (0 = empty).
REQ-002 CLOCK_50  input  1  system clock; all state changes on rising edge.
REQ-003 Resetn  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a full-board row-clear pass; sampled only in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 done  output  1  one-cycle pulse marking pass completion.
REQ-007 linesCleared  output  5  full rows removed in the last pass.
REQ-008 memX  output  4  board column address.
REQ-009 memY  output  5  board row address (0 = top).
REQ-010 memWE  output  1  board write enable.
REQ-011 memWData  output  CW  write data.
REQ-012 memRData  input  CW  read data, valid one cycle after address is driven.

Function
REQ-013 States SHALL be IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, TOP_CLR, DONE; registers: row y (5b), col x (4b), shift row r (5b), count (5b).
REQ-014 IDLE: on start=1, clear count and linesCleared, set y=BOARD_H-1, x=0, go SCAN_RD; otherwise stay, start ignored.
REQ-015 SCAN_RD: drive (x,y), memWE=0, go SCAN_CHK.
REQ-016 SCAN_CHK: if memRData=0 the row is not full: if y=0 go DONE, else y<=y-1, x<=0, go SCAN_RD.
REQ-017 SCAN_CHK: if memRData!=0 and x<BOARD_W-1, x<=x+1, go SCAN_RD; if x=BOARD_W-1 the row is full: r<=y, x<=0, go SHIFT_RD if y>0, else TOP_CLR.
REQ-018 SHIFT_RD: drive (x,r-1), memWE=0, go SHIFT_WR.
REQ-019 SHIFT_WR: drive (x,r), memWE=1, memWData=memRData; if x<BOARD_W-1, x<=x+1, go SHIFT_RD; else x<=0 and, if r=1, go TOP_CLR, else r<=r-1, go SHIFT_RD.
REQ-020 TOP_CLR: drive (x,0), memWE=1, memWData=0; x increments each cycle; after x=BOARD_W-1: count<=count+1, x<=0, go SCAN_RD with y unchanged (same row re-checked).
REQ-021 DONE: linesCleared<=count, done=1 for exactly this cycle, go IDLE.
REQ-022 memWE SHALL be 1 only in SHIFT_WR and TOP_CLR; memX/memY/memWData SHALL be 0 in IDLE and DONE.
REQ-023 Timing: empty board SHALL take exactly 2 cycles per row; done high in the 41st cycle after the start edge for 10x20.
REQ-024 Full-row removal cost SHALL be 2*BOARD_W*y + BOARD_W cycles plus scan cycles; row 0 full costs BOARD_W clear cycles only.
REQ-025 count SHALL never exceed BOARD_H (fits 5 bits); no wrap.
REQ-026 Pass SHALL always terminate: each clear empties row 0, bounding removals to BOARD_H.

Reset
REQ-027 Resetn=0 at a clock edge SHALL force IDLE, busy=0, done=0, memWE=0, address/data=0, linesCleared=0, count=0, regardless of state.
REQ-028 Reset mid-shift SHALL abort immediately; partially shifted board contents are not restored.

Verification
REQ-029 Empty board, start pulse -> no memWE, done in cycle 41, linesCleared=0, busy high cycles 1-40.
REQ-030 Row 19 all colour 2, row 18 only x=3 colour 5 -> after done: row 19 x=3=5, others 0; row 0 all 0; linesCleared=1.
REQ-031 Rows 18 and 19 full, row 17 x=0 colour 1 -> row 19 x=0=1 only, rows 17-18 empty, linesCleared=2.
REQ-032 Only row 0 full -> row 0 cleared in 10 write cycles, no SHIFT states, linesCleared=1.
REQ-033 start re-asserted while busy -> ignored, single done pulse; next start after done runs a new pass and clears linesCleared at start.
REQ-034 Resetn=0 during SHIFT_WR -> next cycle busy=0, memWE=0, linesCleared=0; subsequent start runs normally.
